// File: rtl/exec_sequencer_if.sv
// Memory-side handshake bundle for exec_sequencer: instruction fetch and data access.
// The sequencer owns the request side (master); the memories own the response side (slave).
interface exec_sequencer_if;
  logic        imem_req;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic        dmem_rvalid;

  modport master (
    output imem_req,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata,
    output dmem_req,
    output dmem_we,
    input  dmem_ready,
    input  dmem_rvalid
  );

  modport slave (
    input  imem_req,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata,
    input  dmem_req,
    input  dmem_we,
    output dmem_ready,
    output dmem_rvalid
  );
endinterface

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle fetch / execute / memory / writeback controller for the RV64 datapath.
// Holds the instruction register, runs the imem/dmem valid-ready handshakes one transaction at a
// time, and emits single-cycle PC and register-file write strobes. Stops for good on ebreak, and
// falls into a sticky error state if any memory handshake stalls for TIMEOUT_CYCLES cycles.
module exec_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned CNT_W          = 64
) (
  input  logic               clk,
  input  logic               rst,
  exec_sequencer_if.master   mem,
  output logic [31:0]        instr_out,
  input  logic               dec_is_load,
  input  logic               dec_is_store,
  input  logic               dec_wb_en,
  input  logic               dec_is_ebreak,
  output logic               pc_we,
  output logic               rf_we,
  output logic               halted,
  output logic               err,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    IF_REQ,
    IF_WAIT,
    EX,
    MEM_REQ,
    MEM_WAIT,
    WB,
    HALT,
    ERR
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [31:0]        ir_q;
  logic               imem_req_q;
  logic               dmem_req_q;
  logic               dmem_we_q;
  logic               pc_we_q;
  logic               rf_we_q;
  logic               halted_q;
  logic               err_q;
  logic [CNT_W-1:0]   cycle_cnt_q;
  logic [CNT_W-1:0]   instr_cnt_q;
  logic               timed_out;
  logic               waiting;

  assign timed_out = (wait_q == WAIT_LAST);
  assign waiting   = (state_q == IF_REQ) || (state_q == IF_WAIT) ||
                     (state_q == MEM_REQ) || (state_q == MEM_WAIT);

  // Next-state selection; progress on a handshake always beats the timeout on the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     state_d = IF_REQ;
      IF_REQ:   if (mem.imem_ready)       state_d = IF_WAIT;
                else if (timed_out)       state_d = ERR;
      IF_WAIT:  if (mem.imem_rvalid)      state_d = EX;
                else if (timed_out)       state_d = ERR;
      EX:       if (dec_is_ebreak)        state_d = HALT;
                else if (dec_is_load || dec_is_store) state_d = MEM_REQ;
                else                      state_d = WB;
      MEM_REQ:  if (mem.dmem_ready)       state_d = dec_is_load ? MEM_WAIT : WB;
                else if (timed_out)       state_d = ERR;
      MEM_WAIT: if (mem.dmem_rvalid)      state_d = WB;
                else if (timed_out)       state_d = ERR;
      WB:       state_d = IF_REQ;
      HALT:     state_d = HALT;
      ERR:      state_d = ERR;
      default:  state_d = IDLE;
    endcase
  end

  // Stall counter restarts on every state change and only advances in handshake states.
  always_comb begin
    wait_d = '0;
    if ((state_d == state_q) && waiting) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // State, IR, counters and all outputs are registered, decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      ir_q        <= 32'h0;
      imem_req_q  <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      pc_we_q     <= 1'b0;
      rf_we_q     <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      imem_req_q <= (state_d == IF_REQ);
      dmem_req_q <= (state_d == MEM_REQ);
      dmem_we_q  <= (state_d == MEM_REQ) && dec_is_store && !dec_is_load;
      pc_we_q    <= (state_d == WB);
      rf_we_q    <= (state_d == WB) && dec_wb_en;
      halted_q   <= (state_d == HALT);
      err_q      <= (state_d == ERR);
      if ((state_q == IF_WAIT) && mem.imem_rvalid) begin
        ir_q <= mem.imem_rdata;
      end
      if ((state_q != HALT) && (state_q != ERR)) begin
        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      end
      if (state_q == WB) begin
        instr_cnt_q <= instr_cnt_q + CNT_W'(1);
      end
    end
  end

  assign mem.imem_req = imem_req_q;
  assign mem.dmem_req = dmem_req_q;
  assign mem.dmem_we  = dmem_we_q;
  assign instr_out    = ir_q;
  assign pc_we        = pc_we_q;
  assign rf_we        = rf_we_q;
  assign halted       = halted_q;
  assign err          = err_q;
  assign cycle_cnt    = cycle_cnt_q;
  assign instr_cnt    = instr_cnt_q;

endmodule
